// File: rtl/score_event_arbiter_pkg.sv
// Shared point-code constants, lane count and update record for the score event arbiter.
package score_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [3:0] PT_NONE  = 4'b0000;
  localparam logic [3:0] PT_PLUS1 = 4'b0001;
  localparam logic [3:0] PT_PLUS2 = 4'b0010;
  localparam logic [3:0] PT_NEG2  = 4'b1110;

  typedef struct packed {
    logic [3:0] pt;
    logic [1:0] lane;
  } upd_t;

  function automatic logic is_legal_pt(input logic [3:0] pt);
    return (pt == PT_NONE) || (pt == PT_PLUS1) || (pt == PT_PLUS2) || (pt == PT_NEG2);
  endfunction

endpackage

// File: rtl/score_event_arbiter_if.sv
// Valid/ready update port from the arbiter to the score datapath.
interface score_event_arbiter_if;
  logic       upd_valid;
  logic       upd_ready;
  logic [3:0] upd_pt;
  logic [1:0] upd_lane;

  modport master (output upd_valid, output upd_pt, output upd_lane, input upd_ready);
  modport slave  (input upd_valid, input upd_pt, input upd_lane, output upd_ready);
endinterface

// File: rtl/score_event_arbiter_lane_fifo.sv
// Per-lane point-code FIFO; a push into a full FIFO lands only when the same cycle also pops.
module lane_fifo #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = nxt(wr_q);
    end
    if (do_pop) rd_d = nxt(rd_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/score_event_arbiter.sv
// Captures per-lane point codes into FIFOs and issues them round-robin over a valid/ready port.
// Optional combo doubling is enabled by defining SCORE_ARB_COMBO_EN.
module score_event_arbiter
  import score_pkg::*;
#(
  parameter int DEPTH = 2
`ifdef SCORE_ARB_COMBO_EN
  , parameter int COMBO_LEN = 4
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            pt_0,
  input  logic [3:0]            pt_1,
  input  logic [3:0]            pt_2,
  input  logic [3:0]            pt_3,
  score_event_arbiter_if.master upd,
  output logic [NUM_LANES-1:0]  drop_flags,
  output logic                  illegal_flag,
  output logic                  busy
);
  logic [NUM_LANES-1:0][3:0] pt_in, fifo_dout;
  logic [NUM_LANES-1:0]      legal_nz, bad, push, pop, empty, full;

  upd_t                 upd_q, upd_d;
  logic                 upd_valid_q, upd_valid_d;
  logic [1:0]           rr_q, rr_d, gnt_lane;
  logic [NUM_LANES-1:0] drop_q, drop_d;
  logic                 ill_q, ill_d;
  logic                 free, found, grant;

  assign pt_in = {pt_3, pt_2, pt_1, pt_0};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign legal_nz[g] = is_legal_pt(pt_in[g]) && (pt_in[g] != PT_NONE);
    assign bad[g]      = !is_legal_pt(pt_in[g]);
    assign push[g]     = legal_nz[g] && (!full[g] || pop[g]);

    lane_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (pt_in[g]),
      .dout  (fifo_dout[g]),
      .empty (empty[g]),
      .full  (full[g])
    );
  end

  assign free = !upd_valid_q || upd.upd_ready;

  // First non-empty lane at or after rr_q, wrapping mod 4.
  always_comb begin
    logic [1:0] idx;
    found    = 1'b0;
    gnt_lane = rr_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = rr_q + 2'(k);
      if (!found && !empty[idx]) begin
        found    = 1'b1;
        gnt_lane = idx;
      end
    end
  end

  assign grant = free && found;
  assign pop   = grant ? (NUM_LANES'(1) << gnt_lane) : '0;

`ifdef SCORE_ARB_COMBO_EN
  localparam int CBW = $clog2(COMBO_LEN + 1);
  logic [CBW-1:0] combo_q, combo_d;
`endif

  always_comb begin
    upd_d       = upd_q;
    upd_valid_d = upd_valid_q;
    rr_d        = rr_q;
    drop_d      = drop_q | (legal_nz & full & ~pop);
    ill_d       = ill_q | (|bad);
`ifdef SCORE_ARB_COMBO_EN
    combo_d     = combo_q;
`endif
    if (free) begin
      upd_valid_d = found;
      if (found) begin
        upd_d.pt   = fifo_dout[gnt_lane];
        upd_d.lane = gnt_lane;
        rr_d       = gnt_lane + 2'd1;
`ifdef SCORE_ARB_COMBO_EN
        if (fifo_dout[gnt_lane][3]) begin
          combo_d = '0;
        end else if (combo_q == CBW'(COMBO_LEN)) begin
          upd_d.pt = fifo_dout[gnt_lane] << 1;
        end else begin
          combo_d = combo_q + CBW'(1);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_q       <= '0;
      upd_valid_q <= 1'b0;
      rr_q        <= '0;
      drop_q      <= '0;
      ill_q       <= 1'b0;
`ifdef SCORE_ARB_COMBO_EN
      combo_q     <= '0;
`endif
    end else begin
      upd_q       <= upd_d;
      upd_valid_q <= upd_valid_d;
      rr_q        <= rr_d;
      drop_q      <= drop_d;
      ill_q       <= ill_d;
`ifdef SCORE_ARB_COMBO_EN
      combo_q     <= combo_d;
`endif
    end
  end

  assign upd.upd_valid = upd_valid_q;
  assign upd.upd_pt    = upd_q.pt;
  assign upd.upd_lane  = upd_q.lane;
  assign drop_flags    = drop_q;
  assign illegal_flag  = ill_q;
  assign busy          = (|(~empty)) || upd_valid_q;
endmodule

// File: tb/tb_score_event_arbiter.sv
// Directed bench for score_event_arbiter: latency, round-robin order, full-FIFO drop, illegal codes, reset, combo.
module tb_score_event_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pt_0, pt_1, pt_2, pt_3;
  logic [3:0] drop_flags;
  logic       illegal_flag, busy;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         hs;
  logic [3:0] codes [7];
  logic [3:0] expv  [7];

  score_event_arbiter_if u_if ();

  score_event_arbiter #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .pt_0         (pt_0),
    .pt_1         (pt_1),
    .pt_2         (pt_2),
    .pt_3         (pt_3),
    .upd          (u_if),
    .drop_flags   (drop_flags),
    .illegal_flag (illegal_flag),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pt_0 = 0; pt_1 = 0; pt_2 = 0; pt_3 = 0;
    u_if.upd_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", u_if.upd_valid, 0);
    chk("rst_pt",    u_if.upd_pt,    0);
    chk("rst_lane",  u_if.upd_lane,  0);
    chk("rst_drop",  drop_flags,     0);
    chk("rst_ill",   illegal_flag,   0);
    chk("rst_busy",  busy,           0);
    rst = 1'b0;

    // single event: two-cycle latency, one-cycle pulse
    pt_2 = 4'h1;
    tick(); pt_2 = 4'h0;
    chk("t1_n1_valid", u_if.upd_valid, 0);
    chk("t1_n1_busy",  busy,           1);
    tick();
    chk("t1_n2_valid", u_if.upd_valid, 1);
    chk("t1_n2_pt",    u_if.upd_pt,    1);
    chk("t1_n2_lane",  u_if.upd_lane,  2);
    tick();
    chk("t1_n3_valid", u_if.upd_valid, 0);
    chk("t1_n3_busy",  busy,           0);

    // all lanes at once, round-robin from lane 0
    rst_pulse();
    pt_0 = 4'h2; pt_1 = 4'h2; pt_2 = 4'h2; pt_3 = 4'h2;
    tick(); pt_0 = 0; pt_1 = 0; pt_2 = 0; pt_3 = 0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_valid%0d", k), u_if.upd_valid, 1);
      chk($sformatf("t2_lane%0d", k),  u_if.upd_lane,  k);
      chk($sformatf("t2_pt%0d", k),    u_if.upd_pt,    2);
      tick();
    end
    chk("t2_end_valid", u_if.upd_valid, 0);

    // backpressure fills lane 0, fourth event dropped
    u_if.upd_ready = 1'b0;
    pt_0 = 4'h1;
    tick(); tick(); tick(); tick();
    pt_0 = 4'h0;
    chk("t3_drop",  drop_flags,     4'b0001);
    chk("t3_valid", u_if.upd_valid, 1);
    chk("t3_pt",    u_if.upd_pt,    1);
    chk("t3_lane",  u_if.upd_lane,  0);
    u_if.upd_ready = 1'b1;
    hs = 0;
    for (int k = 0; k < 6; k++) begin
      if (u_if.upd_valid && u_if.upd_ready) hs++;
      tick();
    end
    chk("t3_hs",        hs,         3);
    chk("t3_drop_keep", drop_flags, 4'b0001);
    chk("t3_busy",      busy,       0);

    // illegal code ignored but flagged; legal code still issues
    pt_1 = 4'b0101;
    tick(); pt_1 = 4'h0;
    chk("t4_ill",    illegal_flag,   1);
    chk("t4_valid",  u_if.upd_valid, 0);
    chk("t4_busy",   busy,           0);
    tick();
    chk("t4_valid2", u_if.upd_valid, 0);
    pt_1 = 4'h2;
    tick(); pt_1 = 4'h0;
    tick();
    chk("t4_ok_valid", u_if.upd_valid, 1);
    chk("t4_ok_lane",  u_if.upd_lane,  1);
    chk("t4_ok_pt",    u_if.upd_pt,    2);
    chk("t4_ill_keep", illegal_flag,   1);
    tick();
    chk("t4_end_valid", u_if.upd_valid, 0);

    // reset with a pending update and queued events
    u_if.upd_ready = 1'b0;
    pt_0 = 4'h1; pt_1 = 4'h1; pt_2 = 4'h1;
    tick(); pt_0 = 0; pt_1 = 0; pt_2 = 0;
    tick();
    chk("t5_pre_valid", u_if.upd_valid, 1);
    chk("t5_pre_lane",  u_if.upd_lane,  2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid", u_if.upd_valid, 0);
    chk("t5_pt",    u_if.upd_pt,    0);
    chk("t5_lane",  u_if.upd_lane,  0);
    chk("t5_drop",  drop_flags,     0);
    chk("t5_ill",   illegal_flag,   0);
    chk("t5_busy",  busy,           0);
    u_if.upd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t5_quiet%0d", k), u_if.upd_valid | busy, 0);
    end

    // five +1, then -2, then +1 streamed back to back on lane 0
    rst_pulse();
    codes = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'he, 4'h1};
`ifdef SCORE_ARB_COMBO_EN
    expv  = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'he, 4'h1};
`else
    expv  = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'he, 4'h1};
`endif
    for (int j = 0; j < 9; j++) begin
      pt_0 = (j < 7) ? codes[j] : 4'h0;
      if (j >= 2) begin
        chk($sformatf("t6_valid%0d", j - 2), u_if.upd_valid, 1);
        chk($sformatf("t6_pt%0d", j - 2),    u_if.upd_pt,    expv[j-2]);
      end
      tick();
    end
    chk("t6_end_valid", u_if.upd_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
